wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, meaning the number of producer (execution-unit) ports.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the FIFO entries per source.
REQ-003 SHALL have parameter PREG_WIDTH, default 6, meaning the physical register index width (`PREG_RANGE).
REQ-004 SHALL have parameter ROBID_WIDTH, default `INSTR_ID_WIDTH+1, meaning the ROB index plus wrap bit.
REQ-005 SHALL have ports as follows; one clock; reset is synchronous and active-high:
  clock  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
  src_valid  in  NUM_SRC  producer result valid
  src_ready  out  NUM_SRC  buffer can accept
  src_need_to_wb  in  NUM_SRC  result writes a preg
  src_prd  in  NUM_SRC x PREG_WIDTH  destination preg
  src_robid  in  NUM_SRC x ROBID_WIDTH  producer ROB id
  writeback0_valid / writeback1_valid  out  1  broadcast valid
  writeback0_need_to_wb / writeback1_need_to_wb  out  1  copied from entry
  writeback0_prd / writeback1_prd  out  PREG_WIDTH  woken preg
  writeback0_robid / writeback1_robid  out  ROBID_WIDTH  completing ROB id
  flush_valid  in  1  pipeline flush
  flush_robid  in  ROBID_WIDTH  flush boundary; strictly younger entries are killed

Function
REQ-006 SHALL keep one BUF_DEPTH circular FIFO per source holding {need_to_wb, prd, robid}, with 2-bit-wide-enough count, head and tail pointers wrapping modulo BUF_DEPTH.
REQ-007 SHALL drive src_ready[i] = (count[i] < BUF_DEPTH), from registered state only, with no path from src_valid.
REQ-008 SHALL enqueue on src_valid[i] && src_ready[i]; no bypass; an entry enqueued in cycle N is earliest visible on a writeback port in cycle N+2.
REQ-009 SHALL each cycle grant up to two non-empty source heads, scanning from rr_ptr upward modulo NUM_SRC; the first grant goes to port 0, the second to port 1.
REQ-010 SHALL advance rr_ptr to (last granted source + 1) mod NUM_SRC when any grant occurs, and otherwise hold it; rr_ptr resets to 0.
REQ-011 SHALL pop granted heads in the grant cycle and register their fields into the writeback outputs; outputs are valid exactly one cycle and deassert when no grant occurs.
REQ-012 SHALL never grant port 1 without port 0; writeback1_valid implies writeback0_valid.
REQ-013 SHALL handle simultaneous push and pop on one FIFO with count unchanged; push to a full FIFO cannot occur.
REQ-014 SHALL arbitrate entries with need_to_wb=0 identically to other entries (completion report only).
REQ-015 SHALL use the age rule younger(a,b) = (a.wrap != b.wrap) ? (a.idx < b.idx) : (a.idx > b.idx), where wrap is the MSB.
REQ-016 SHALL, on flush_valid, invalidate in that cycle every buffered entry younger than flush_robid, exclude those entries from that cycle's grant, and drop any same-cycle enqueue younger than flush_robid.
REQ-017 SHALL compact surviving entries after a flush so that FIFO order is preserved (the tail retracts; flushed entries are always a youngest suffix per source).
REQ-018 SHALL leave already-registered writeback outputs unchanged by a flush in the same cycle.

Reset
REQ-019 SHALL, on reset, clear all counts, pointers and rr_ptr to 0, set all writeback*_valid, need_to_wb, prd and robid to 0, and drive src_ready all-1 in the following cycle.
REQ-020 SHALL give reset priority over flush, enqueue and grant, and SHALL discard in-flight entries when reset asserts mid-operation.

Configuration
REQ-021 SHALL, when WB_ARB_PERF_EN is defined, add output perf_wb_stall_cnt [31:0], which increments (wrapping) each cycle where a non-empty head is not granted, and resets to 0.
REQ-022 SHALL, when WB_ARB_PERF_EN is undefined, omit that port and counter, with arbitration behaviour identical.

Verification
REQ-023 SHALL cover single result: src0 prd=5 robid=3 in cycle 1 -> writeback0_valid=1, prd=5 in cycle 3, and writeback1_valid=0.
REQ-024 SHALL cover three-source contention: all three sources valid in cycle 1 with rr_ptr=0 -> cycle 3 gives port0=src0, port1=src1; cycle 4 gives port0=src2; rr_ptr ends at 0.
REQ-025 SHALL cover backpressure: src1 holds 2 entries with no grants possible -> src_ready[1]=0; after one pop, src_ready[1]=1 the next cycle.
REQ-026 SHALL cover flush with wrap: buffered robids {0x1E, 0x21 (wrap set)}, flush_robid=0x1F -> 0x21 is killed and 0x1E is broadcast.
REQ-027 SHALL cover reset mid-stream: reset asserted with 4 entries buffered -> no writeback valid afterward and all src_ready=1.
REQ-028 SHALL cover perf counting: with WB_ARB_PERF_EN defined and 3 heads non-empty for 1 cycle -> perf_wb_stall_cnt=1.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter for NUM_SRC execution-unit result ports.
// Each source feeds a small circular FIFO. Every cycle up to two
// non-empty heads are granted round-robin onto two registered writeback
// broadcast ports. A flush kills buffered and incoming entries younger
// than the flush boundary.
// Optional feature macro: WB_ARB_PERF_EN adds perf_wb_stall_cnt.
`ifndef INSTR_ID_WIDTH
`define INSTR_ID_WIDTH 5
`endif

module wb_arbiter #(
  parameter int NUM_SRC     = 3,
  parameter int BUF_DEPTH   = 2,
  parameter int PREG_WIDTH  = 6,
  parameter int ROBID_WIDTH = `INSTR_ID_WIDTH + 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NUM_SRC-1:0]                    src_valid,
  output logic [NUM_SRC-1:0]                    src_ready,
  input  logic [NUM_SRC-1:0]                    src_need_to_wb,
  input  logic [NUM_SRC-1:0][PREG_WIDTH-1:0]    src_prd,
  input  logic [NUM_SRC-1:0][ROBID_WIDTH-1:0]   src_robid,
  output logic                                  writeback0_valid,
  output logic                                  writeback0_need_to_wb,
  output logic [PREG_WIDTH-1:0]                 writeback0_prd,
  output logic [ROBID_WIDTH-1:0]                writeback0_robid,
  output logic                                  writeback1_valid,
  output logic                                  writeback1_need_to_wb,
  output logic [PREG_WIDTH-1:0]                 writeback1_prd,
  output logic [ROBID_WIDTH-1:0]                writeback1_robid,
  input  logic                                  flush_valid,
  input  logic [ROBID_WIDTH-1:0]                flush_robid
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]                           perf_wb_stall_cnt
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef struct packed {
    logic                   need_to_wb;
    logic [PREG_WIDTH-1:0]  prd;
    logic [ROBID_WIDTH-1:0] robid;
  } entry_t;

  // a is younger than b; MSB is the ROB wrap bit
  function automatic logic younger(input logic [ROBID_WIDTH-1:0] a,
                                   input logic [ROBID_WIDTH-1:0] b);
    logic [ROBID_WIDTH-2:0] ai;
    logic [ROBID_WIDTH-2:0] bi;
    ai = a[ROBID_WIDTH-2:0];
    bi = b[ROBID_WIDTH-2:0];
    if (a[ROBID_WIDTH-1] != b[ROBID_WIDTH-1]) return (ai < bi);
    else                                      return (ai > bi);
  endfunction

  // callers never pass more than 2*BUF_DEPTH-1, so one subtract suffices
  function automatic logic [PTR_W-1:0] ptr_wrap(input int v);
    int t;
    t = (v >= BUF_DEPTH) ? v - BUF_DEPTH : v;
    return PTR_W'(t);
  endfunction

  function automatic logic [SRC_W-1:0] src_wrap(input int v);
    int t;
    t = (v >= NUM_SRC) ? v - NUM_SRC : v;
    return SRC_W'(t);
  endfunction

  // FIFO state
  entry_t           r_mem  [NUM_SRC][BUF_DEPTH];
  logic [PTR_W-1:0] r_head [NUM_SRC];
  logic [PTR_W-1:0] r_tail [NUM_SRC];
  logic [CNT_W-1:0] r_cnt  [NUM_SRC];
  logic [SRC_W-1:0] r_rr;

  // per-source next-state helpers
  logic [CNT_W-1:0] w_surv   [NUM_SRC];
  logic [PTR_W-1:0] w_wr_idx [NUM_SRC];
  entry_t           w_head_ent [NUM_SRC];
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_kill;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;

  // grant selection
  logic             w_g0_vld, w_g1_vld;
  logic [SRC_W-1:0] w_g0_src, w_g1_src, w_last, w_rr_nxt;

  // registered writeback ports
  logic                   r_wb0_vld, r_wb0_need, r_wb1_vld, r_wb1_need;
  logic [PREG_WIDTH-1:0]  r_wb0_prd, r_wb1_prd;
  logic [ROBID_WIDTH-1:0] r_wb0_robid, r_wb1_robid;

  // ready depends only on registered occupancy
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++)
      src_ready[s] = (r_cnt[s] < CNT_W'(BUF_DEPTH));
  end

  // survivors after flush (always an oldest prefix), push qualification,
  // and write slot: a flush retracts the tail to just past the survivors
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      w_surv[s] = '0;
      for (int k = 0; k < BUF_DEPTH; k++) begin
        if ((k < int'(r_cnt[s])) &&
            !(flush_valid &&
              younger(r_mem[s][ptr_wrap(int'(r_head[s]) + k)].robid, flush_robid)))
          w_surv[s] = w_surv[s] + CNT_W'(1);
      end
      w_elig[s]     = (w_surv[s] != '0);
      w_kill[s]     = (w_surv[s] != r_cnt[s]);
      w_push[s]     = src_valid[s] && src_ready[s] &&
                      !(flush_valid && younger(src_robid[s], flush_robid));
      w_wr_idx[s]   = w_kill[s] ? ptr_wrap(int'(r_head[s]) + int'(w_surv[s])) : r_tail[s];
      w_head_ent[s] = r_mem[s][r_head[s]];
    end
  end

  // round-robin pick of up to two eligible heads starting at r_rr
  always_comb begin
    w_g0_vld = 1'b0;
    w_g1_vld = 1'b0;
    w_g0_src = '0;
    w_g1_src = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (w_elig[src_wrap(int'(r_rr) + k)]) begin
        if (!w_g0_vld) begin
          w_g0_vld = 1'b1;
          w_g0_src = src_wrap(int'(r_rr) + k);
        end else if (!w_g1_vld) begin
          w_g1_vld = 1'b1;
          w_g1_src = src_wrap(int'(r_rr) + k);
        end
      end
    end
    w_pop = '0;
    if (w_g0_vld) w_pop[w_g0_src] = 1'b1;
    if (w_g1_vld) w_pop[w_g1_src] = 1'b1;
    w_last   = w_g1_vld ? w_g1_src : w_g0_src;
    w_rr_nxt = w_g0_vld ? src_wrap(int'(w_last) + 1) : r_rr;
  end

  // FIFO payload storage; occupancy is reset separately so no reset here
  always_ff @(posedge clock) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (w_push[s])
        r_mem[s][w_wr_idx[s]] <= '{need_to_wb: src_need_to_wb[s],
                                   prd:        src_prd[s],
                                   robid:      src_robid[s]};
    end
  end

  // FIFO pointers, counts and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        r_head[s] <= '0;
        r_tail[s] <= '0;
        r_cnt[s]  <= '0;
      end
      r_rr <= '0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        r_head[s] <= w_pop[s] ? ptr_wrap(int'(r_head[s]) + 1) : r_head[s];
        r_cnt[s]  <= w_surv[s] - CNT_W'(w_pop[s]) + CNT_W'(w_push[s]);
        r_tail[s] <= ptr_wrap(int'(r_head[s]) + int'(w_surv[s]) + int'(w_push[s]));
      end
      r_rr <= w_rr_nxt;
    end
  end

  // writeback broadcast registers; fields hold when the port idles
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb0_vld   <= 1'b0;
      r_wb0_need  <= 1'b0;
      r_wb0_prd   <= '0;
      r_wb0_robid <= '0;
      r_wb1_vld   <= 1'b0;
      r_wb1_need  <= 1'b0;
      r_wb1_prd   <= '0;
      r_wb1_robid <= '0;
    end else begin
      r_wb0_vld <= w_g0_vld;
      r_wb1_vld <= w_g1_vld;
      if (w_g0_vld) begin
        r_wb0_need  <= w_head_ent[w_g0_src].need_to_wb;
        r_wb0_prd   <= w_head_ent[w_g0_src].prd;
        r_wb0_robid <= w_head_ent[w_g0_src].robid;
      end
      if (w_g1_vld) begin
        r_wb1_need  <= w_head_ent[w_g1_src].need_to_wb;
        r_wb1_prd   <= w_head_ent[w_g1_src].prd;
        r_wb1_robid <= w_head_ent[w_g1_src].robid;
      end
    end
  end

  assign writeback0_valid      = r_wb0_vld;
  assign writeback0_need_to_wb = r_wb0_need;
  assign writeback0_prd        = r_wb0_prd;
  assign writeback0_robid      = r_wb0_robid;
  assign writeback1_valid      = r_wb1_vld;
  assign writeback1_need_to_wb = r_wb1_need;
  assign writeback1_prd        = r_wb1_prd;
  assign writeback1_robid      = r_wb1_robid;

`ifdef WB_ARB_PERF_EN
  logic        w_stall;
  logic [31:0] r_stall_cnt;
  assign w_stall = |(w_elig & ~w_pop);

  // count cycles where some live head lost arbitration
  always_ff @(posedge clock) begin
    if (reset)        r_stall_cnt <= '0;
    else if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign perf_wb_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter (3 sources, depth 2,
// 6-bit preg, 6-bit robid with wrap at bit 5).
module tb_wb_arbiter;
  localparam int NS = 3;
  localparam int PW = 6;
  localparam int RW = 6;
  localparam int NV = 27;

  logic                   clock, reset;
  logic [NS-1:0]          src_valid, src_ready, src_need;
  logic [NS-1:0][PW-1:0]  src_prd;
  logic [NS-1:0][RW-1:0]  src_robid;
  logic                   wb0_v, wb0_n, wb1_v, wb1_n;
  logic [PW-1:0]          wb0_p, wb1_p;
  logic [RW-1:0]          wb0_r, wb1_r;
  logic                   flush_valid;
  logic [RW-1:0]          flush_robid;
`ifdef WB_ARB_PERF_EN
  logic [31:0]            perf_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  wb_arbiter #(.NUM_SRC(NS), .BUF_DEPTH(2), .PREG_WIDTH(PW), .ROBID_WIDTH(RW)) dut (
    .clock(clock), .reset(reset),
    .src_valid(src_valid), .src_ready(src_ready), .src_need_to_wb(src_need),
    .src_prd(src_prd), .src_robid(src_robid),
    .writeback0_valid(wb0_v), .writeback0_need_to_wb(wb0_n),
    .writeback0_prd(wb0_p), .writeback0_robid(wb0_r),
    .writeback1_valid(wb1_v), .writeback1_need_to_wb(wb1_n),
    .writeback1_prd(wb1_p), .writeback1_robid(wb1_r),
    .flush_valid(flush_valid), .flush_robid(flush_robid)
`ifdef WB_ARB_PERF_EN
    , .perf_wb_stall_cnt(perf_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [NS-1:0]         v;
    logic [NS-1:0]         nd;
    logic [NS-1:0][PW-1:0] p;
    logic [NS-1:0][RW-1:0] r;
    logic                  fv;
    logic [RW-1:0]         fr;
    logic                  av, an;
    logic [PW-1:0]         ap;
    logic [RW-1:0]         ar;
    logic                  bv, bn;
    logic [PW-1:0]         bp;
    logic [RW-1:0]         br;
    logic [NS-1:0]         rdy;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t row(input int v, input int nd,
                               input int p2, input int p1, input int p0,
                               input int r2, input int r1, input int r0,
                               input int fv, input int fr,
                               input int av, input int an, input int ap, input int ar,
                               input int bv, input int bn, input int bp, input int br,
                               input int rdy);
    vec_t x;
    x.v = NS'(v);  x.nd = NS'(nd);
    x.p[0] = PW'(p0); x.p[1] = PW'(p1); x.p[2] = PW'(p2);
    x.r[0] = RW'(r0); x.r[1] = RW'(r1); x.r[2] = RW'(r2);
    x.fv = 1'(fv); x.fr = RW'(fr);
    x.av = 1'(av); x.an = 1'(an); x.ap = PW'(ap); x.ar = RW'(ar);
    x.bv = 1'(bv); x.bn = 1'(bn); x.bp = PW'(bp); x.br = RW'(br);
    x.rdy = NS'(rdy);
    return x;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [NS-1:0] v, input logic [NS-1:0][PW-1:0] p,
                       input logic [NS-1:0][RW-1:0] r);
    src_valid = v; src_need = '1; src_prd = p; src_robid = r;
  endtask

  initial begin
    //        v  nd  p2 p1 p0  r2   r1   r0   fv fr    av an ap ar    bv bn bp br    rdy
    tbl[0]  = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    // three-way contention from rr=0; src2 is a completion-only entry
    tbl[1]  = row(7, 3,  3, 2, 1,  4,   2,   1,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    tbl[2]  = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    1, 1, 1, 1,     1, 1, 2, 2,    7);
    tbl[3]  = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    1, 0, 3, 4,     0, 0, 0, 0,    7);
    tbl[4]  = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    // rr must be back at 0: src1 wins port0
    tbl[5]  = row(6, 7, 21,20, 0, 10,   9,   0,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    tbl[6]  = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    1, 1,20, 9,     1, 1,21,10,    7);
    // single result, visible two cycles after enqueue
    tbl[7]  = row(1, 7,  0, 0, 5,  0,   0,   3,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    tbl[8]  = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    1, 1, 5, 3,     0, 0, 0, 0,    7);
    // rr=1: src1 first, then wrap to src0
    tbl[9]  = row(3, 7,  0,11,10,  0,   6,   5,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    tbl[10] = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    1, 1,11, 6,     1, 1,10, 5,    7);
    // flush across the wrap bit; same-cycle younger enqueue dropped
    tbl[11] = row(3, 7,  0,33,30,  0,'h21,'h1E,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    tbl[12] = row(4, 7, 34, 0, 0,'h22,  0,   0,   1,'h1F,  1, 1,30,'h1E,   0, 0, 0, 0,    7);
    tbl[13] = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    // two entries in src0, flush kills only its tail
    tbl[14] = row(7, 7, 42,41,40,  4,   3,   2,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    tbl[15] = row(1, 7,  0, 0,43,  0,   0,   5,   0, 0,    1, 1,41, 3,     1, 1,42, 4,    6);
    tbl[16] = row(0, 7,  0, 0, 0,  0,   0,   0,   1, 4,    1, 1,40, 2,     0, 0, 0, 0,    7);
    tbl[17] = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    tbl[18] = row(1, 7,  0, 0,44,  0,   0,   6,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    tbl[19] = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    1, 1,44, 6,     0, 0, 0, 0,    7);
    // backpressure on src1 (rr steered to 2 so src1 loses)
    tbl[20] = row(2, 7,  0,50, 0,  0,   7,   0,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    tbl[21] = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    1, 1,50, 7,     0, 0, 0, 0,    7);
    tbl[22] = row(7, 7, 53,52,51,'hA,   9,   8,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);
    tbl[23] = row(2, 7,  0,54, 0,  0, 'hB,   0,   0, 0,    1, 1,53,'hA,    1, 1,51, 8,    5);
    tbl[24] = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    1, 1,52, 9,     0, 0, 0, 0,    7);
    tbl[25] = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    1, 1,54,'hB,    0, 0, 0, 0,    7);
    tbl[26] = row(0, 7,  0, 0, 0,  0,   0,   0,   0, 0,    0, 0, 0, 0,     0, 0, 0, 0,    7);

    reset = 1'b1; src_valid = '0; src_need = '0; src_prd = '0; src_robid = '0;
    flush_valid = 1'b0; flush_robid = '0;
    tick(); tick();
    chk("rst_wb0_valid", -1, 32'(wb0_v), 0);
    chk("rst_wb1_valid", -1, 32'(wb1_v), 0);
    chk("rst_wb0_prd",   -1, 32'(wb0_p), 0);
    chk("rst_wb0_robid", -1, 32'(wb0_r), 0);
    chk("rst_ready",     -1, 32'(src_ready), 7);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      src_valid = tbl[i].v;  src_need = tbl[i].nd;
      src_prd   = tbl[i].p;  src_robid = tbl[i].r;
      flush_valid = tbl[i].fv; flush_robid = tbl[i].fr;
      tick();
      chk("wb0_valid", i, 32'(wb0_v), 32'(tbl[i].av));
      chk("wb1_valid", i, 32'(wb1_v), 32'(tbl[i].bv));
      chk("src_ready", i, 32'(src_ready), 32'(tbl[i].rdy));
      if (tbl[i].av) begin
        chk("wb0_need",  i, 32'(wb0_n), 32'(tbl[i].an));
        chk("wb0_prd",   i, 32'(wb0_p), 32'(tbl[i].ap));
        chk("wb0_robid", i, 32'(wb0_r), 32'(tbl[i].ar));
      end
      if (tbl[i].bv) begin
        chk("wb1_need",  i, 32'(wb1_n), 32'(tbl[i].bn));
        chk("wb1_prd",   i, 32'(wb1_p), 32'(tbl[i].bp));
        chk("wb1_robid", i, 32'(wb1_r), 32'(tbl[i].br));
      end
    end
    flush_valid = 1'b0;

    // reset with four entries in flight (rr=2 here)
    drive(3'b111, {6'd62, 6'd61, 6'd60}, {6'h0E, 6'h0D, 6'h0C});
    tick();
    drive(3'b111, {6'd65, 6'd64, 6'd63}, {6'h11, 6'h10, 6'h0F});
    tick();
    chk("mid_wb0_prd", 100, 32'(wb0_p), 62);
    chk("mid_wb1_prd", 100, 32'(wb1_p), 60);
    chk("mid_ready",   100, 32'(src_ready), 5);
    src_valid = '0;
    reset = 1'b1;
    tick();
    chk("rst2_wb0_valid", 101, 32'(wb0_v), 0);
    chk("rst2_wb1_valid", 101, 32'(wb1_v), 0);
    chk("rst2_ready",     101, 32'(src_ready), 7);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("post_rst_wb0_valid", 102 + k, 32'(wb0_v), 0);
      chk("post_rst_wb1_valid", 102 + k, 32'(wb1_v), 0);
      chk("post_rst_ready",     102 + k, 32'(src_ready), 7);
    end

`ifdef WB_ARB_PERF_EN
    chk("perf_after_rst", 110, perf_cnt, 0);
    drive(3'b111, {6'd3, 6'd2, 6'd1}, {6'h03, 6'h02, 6'h01});
    tick();
    src_valid = '0;
    tick();
    chk("perf_one_stall", 111, perf_cnt, 1);
    tick();
    chk("perf_hold", 112, perf_cnt, 1);
    chk("perf_last_wb0", 112, 32'(wb0_p), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
